fifo_rd_drain: RTL and testbench
================================

Name: fifo_rd_drain

Overview:
- Single-clock read-side controller for the async FIFO, sitting in the r_clk domain.
- Watches the FIFO `empty` flag and issues `r_en` only when it has room, then captures the FIFO `data_out`.
- Re-presents captured words on a valid/ready stream through a small skid buffer.
- Gives downstream logic full-throughput, backpressure-safe access to the FIFO with no lost or duplicated words.

Parameters:
- data_width, 8, width of FIFO words and stream data.
- SKID_DEPTH, 2, skid buffer entries; legal values 2..4.

Ports:
- r_clk  input  1  read-domain clock.
- rrst_n  input  1  asynchronous active-low reset.
- en  input  1  drain enable; when 0, no new `r_en` is issued.
- flush  input  1  synchronous clear of the skid buffer and of any in-flight word.
- empty  input  1  FIFO empty flag, synchronous to r_clk.
- r_en  output  1  FIFO read enable, combinational.
- fifo_data  input  data_width  FIFO `data_out`; valid one cycle after `r_en`.
- m_valid  output  1  stream word valid.
- m_data  output  data_width  stream word.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (rrst_n=0, async):
  - occ=0, inflight=0, rd/wr indices=0, storage=0.
  - m_valid=0, m_data=0, r_en=0.
  - Reset mid-transfer discards buffered and in-flight words.
- FIFO contract: the FIFO samples `r_en` at posedge r_clk; the word read is on `fifo_data` during the following cycle.
- pop = m_valid && m_ready.
- r_en = en && !flush && !empty && (occ + inflight - pop) < SKID_DEPTH.
  - Pop is credited in the same cycle, so 1 word/cycle is sustained with m_ready held high.
- inflight register <= r_en each edge.
- Capture: on an edge where inflight=1 and flush=0, write fifo_data at wr index, wr index++ (mod SKID_DEPTH).
- Pop: on an edge where pop=1, rd index++ (mod SKID_DEPTH).
- occ next = occ + capture - pop.
  - Simultaneous capture and pop: occ unchanged.
  - occ width is clog2(SKID_DEPTH+1).
- m_valid = (occ != 0); m_data = storage[rd index]. Both are registered-state driven, with no combinational path from fifo_data.
- Hold rule: while m_valid=1 and m_ready=0, m_data is stable.
- Latency: with en=1, m_ready=1 and buffer empty, `empty` falling in cycle t gives r_en=1 in t, capture at end of t+1, and m_valid=1 in t+2.
- Boundaries:
  - occ=SKID_DEPTH with no pop: r_en=0.
  - empty=1: r_en=0 regardless of credit; the block never reads an empty FIFO.
  - Index wrap-around is modulo SKID_DEPTH.
  - en falling: in-flight word is still captured; buffered words still drain.
  - flush=1: occ<=0, indices<=0, in-flight word is discarded, r_en=0 that cycle, m_valid=0 from the next cycle.
- Assertions (bench):
  - no capture when occ=SKID_DEPTH and no pop;
  - r_en never high while empty.

Optional Feature:
- Macro: FIFO_RD_DRAIN_WORD_COUNT_EN.
- Defined: adds output `word_count` [15:0]. It increments on every pop, wraps 0xFFFF->0, is cleared by reset and by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_rd_pkg holds:
  - default data_width=8 and SKID_DEPTH=2 constants;
  - a function returning occupancy width for a given depth;
  - the word_count width constant (16).
- Sub-module rd_skid_buf:
  - storage array, rd/wr indices and occ counter;
  - inputs: capture, pop, flush, wdata;
  - outputs: occ, head data.
- The top handles credit, `r_en` and the inflight register.

Test Plan:
- Burst: FIFO preloaded with 0..9, en=1, m_ready=1 -> m_data 0..9 in order on 10 consecutive cycles starting 2 cycles after the first r_en; afterwards r_en=0.
- Backpressure: m_ready=0 with 5 words available -> exactly 2 words read (r_en high 2 cycles), occ=2, m_data=first word held stable. Releasing m_ready -> remaining 3 words follow with no gaps or duplicates.
- Alternating m_ready 1010 over 20 words -> all 20 words delivered in order; r_en never high while occ+inflight-pop >= 2.
- Empty edge: single word 0x5A written, empty toggles 1->0->1 -> one r_en pulse; m_valid asserted once with m_data=0x5A.
- Flush mid-stream: flush asserted in the cycle after r_en for word 7, with occ=1 -> m_valid=0 next cycle; word 7 and the buffered word are lost; next delivered word is 8.
- Reset mid-operation: rrst_n pulsed low with occ=2 -> m_valid, r_en and occ all 0 immediately. With FIFO_RD_DRAIN_WORD_COUNT_EN defined, word_count=0, and it reads 10 after the burst test.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared constants and helpers for the FIFO read-drain controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  localparam int unsigned c_DATA_WIDTH   = 8;
  localparam int unsigned c_SKID_DEPTH   = 2;
  localparam int unsigned c_WORD_COUNT_W = 16;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_skid_buf.sv
// ============================================================================
// Module   : rd_skid_buf
// Brief    : Circular skid buffer holding captured FIFO words until popped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = c_SKID_DEPTH,
  parameter int unsigned OCC_W      = occ_width(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_capture,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [OCC_W-1:0]      o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int unsigned c_IDX_W = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [c_IDX_W-1:0]    r_wr_idx;
  logic [c_IDX_W-1:0]    r_rd_idx;
  logic [OCC_W-1:0]      r_occ;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx);
    return (idx == c_IDX_W'(SKID_DEPTH - 1)) ? '0 : idx + c_IDX_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) r_mem[i] <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_occ    <= '0;
    end else begin
      if (i_capture) begin
        r_mem[r_wr_idx] <= i_wdata;
        r_wr_idx        <= next_idx(r_wr_idx);
      end
      if (i_pop) r_rd_idx <= next_idx(r_rd_idx);
      case ({i_capture, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_idx];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ============================================================================
// Module   : fifo_rd_drain
// Brief    : Read-side FIFO drain with credit-based r_en and skid-buffered
//            valid/ready output. Optional word counter: FIFO_RD_DRAIN_WORD_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = c_SKID_DEPTH
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
  ,
  output logic [c_WORD_COUNT_W-1:0] word_count
`endif
);

  localparam int unsigned c_OCC_W = occ_width(SKID_DEPTH);

  logic               r_inflight;
  logic [c_OCC_W-1:0] w_occ;
  logic [c_OCC_W:0]   w_credit;
  logic               w_pop;
  logic               w_capture;

  assign w_pop     = m_valid && m_ready;
  assign w_capture = r_inflight && !flush;

  // Crediting the same-cycle pop lets a full-rate stream sustain one word/cycle.
  assign w_credit = {1'b0, w_occ} + {{c_OCC_W{1'b0}}, r_inflight}
                  - {{c_OCC_W{1'b0}}, w_pop};
  assign r_en = rrst_n && en && !flush && !empty
             && (w_credit < (c_OCC_W + 1)'(SKID_DEPTH));

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) r_inflight <= 1'b0;
    else         r_inflight <= r_en;
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH),
    .OCC_W      (c_OCC_W)
  ) u_skid (
    .clk       (r_clk),
    .rst_n     (rrst_n),
    .i_capture (w_capture),
    .i_pop     (w_pop),
    .i_flush   (flush),
    .i_wdata   (fifo_data),
    .o_occ     (w_occ),
    .o_head    (m_data)
  );

  assign m_valid = (w_occ != '0);

`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
  logic [c_WORD_COUNT_W-1:0] r_word_count;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n)    r_word_count <= '0;
    else if (flush) r_word_count <= '0;
    else if (w_pop) r_word_count <= r_word_count + c_WORD_COUNT_W'(1);
  end

  assign word_count = r_word_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
// ============================================================================
// Module   : tb_fifo_rd_drain
// Brief    : Self-checking bench for fifo_rd_drain with a behavioural FIFO,
//            stream scoreboard and credit invariant monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_rd_drain;

  localparam int SKID = 2;

  logic       clk     = 1'b0;
  logic       rrst_n  = 1'b1;
  logic       en      = 1'b0;
  logic       flush   = 1'b0;
  logic       m_ready = 1'b0;
  logic       empty;
  logic       r_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] fifo_data = 8'h00;
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
  logic [15:0] word_count;
`endif

  logic [7:0]  fmem [256];
  int unsigned fwr = 0;
  int unsigned frd = 0;

  int n_pass  = 0;
  int n_total = 0;

  int         outstanding = 0;
  bit         prev_hold   = 1'b0;
  logic [7:0] prev_data   = 8'h00;
  bit         mon_pop;
  int         rd_count    = 0;
  int         pop_count   = 0;
  logic [7:0] got [$];

  fifo_rd_drain #(
    .DATA_WIDTH (8),
    .SKID_DEPTH (SKID)
  ) dut (
    .r_clk      (clk),
    .rrst_n     (rrst_n),
    .en         (en),
    .flush      (flush),
    .empty      (empty),
    .r_en       (r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears the cycle after the read enable.
  assign empty = (fwr == frd);
  always @(posedge clk) begin
    if (r_en) begin
      fifo_data <= fmem[frd[7:0]];
      frd       <= frd + 1;
    end
  end

  // Stream monitor, sampling 1ns before each rising edge.
  always begin
    @(negedge clk);
    #4;
    n_total++;
    if (r_en && empty) $display("FAIL rd_when_empty: r_en=%b empty=%b required r_en=0", r_en, empty);
    else n_pass++;
    if (!rrst_n) begin
      outstanding = 0;
      prev_hold   = 1'b0;
    end else begin
      if (prev_hold) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
        else n_pass++;
      end
      if (flush) begin
        n_total++;
        if (r_en !== 1'b0) $display("FAIL flush_ren: r_en=%b required 0", r_en);
        else n_pass++;
      end
      mon_pop = m_valid && m_ready;
      if (r_en) rd_count++;
      if (mon_pop && !flush) begin
        got.push_back(m_data);
        pop_count++;
      end
      if (flush) outstanding = 0;
      else       outstanding = outstanding + int'(r_en) - int'(mon_pop);
      n_total++;
      if (outstanding < 0 || outstanding > SKID)
        $display("FAIL credit: outstanding=%0d required 0..%0d", outstanding, SKID);
      else n_pass++;
      prev_hold = m_valid && !m_ready && !flush;
      prev_data = m_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [7:0] v);
    fmem[fwr[7:0]] = v;
    fwr = fwr + 1;
  endtask

  task automatic wait_idle(output bit ok);
    int idle;
    idle    = 0;
    ok      = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (fwr == frd && !m_valid) idle++;
      else idle = 0;
      if (idle >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    got.delete();
    en = 1'b1; m_ready = 1'b0; flush = 1'b0;
    push_word(8'h11);
    #2 rrst_n = 1'b0;
    #1;
    n_total++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || r_en !== 1'b0)
      $display("FAIL reset_outputs: valid=%b data=%h r_en=%b required 0/00/0", m_valid, m_data, r_en);
    else n_pass++;
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
    n_total++;
    if (word_count !== 16'd0) $display("FAIL reset_wc: got %0d required 0", word_count);
    else n_pass++;
`endif
    @(negedge clk);
    rrst_n = 1'b1;
    #1;
    n_total++;
    if (r_en !== 1'b1) $display("FAIL reset_release_ren: r_en=%b required 1", r_en);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != 1 || got[0] !== 8'h11)
      $display("FAIL reset_drain: ok=%b count=%0d required one word 11", ok, got.size());
    else n_pass++;
  endtask

  task automatic test_burst;
    int r0;
    @(negedge clk);
    en = 1'b0; m_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(i));
    got.delete();
    r0 = rd_count;
    en = 1'b1; m_ready = 1'b1;
    #1;
    n_total++;
    if (r_en !== 1'b1) $display("FAIL burst_first_ren: r_en=%b required 1", r_en);
    else n_pass++;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_total++;
      if (m_valid !== 1'b1 || m_data !== 8'(k))
        $display("FAIL burst_word[%0d]: valid=%b data=%h required 1/%h", k, m_valid, m_data, 8'(k));
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (r_en !== 1'b0 || m_valid !== 1'b0 || rd_count - r0 != 10)
      $display("FAIL burst_end: r_en=%b valid=%b reads=%0d required 0/0/10", r_en, m_valid, rd_count - r0);
    else n_pass++;
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
    n_total++;
    if (word_count !== 16'd10) $display("FAIL burst_wc: got %0d required 10", word_count);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure;
    logic [7:0] w [5];
    int r0;
    bit ok;
    got.delete();
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom);
      push_word(w[i]);
    end
    r0 = rd_count;
    @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_total++;
    if (rd_count - r0 != 2) $display("FAIL bp_reads: got %0d required 2", rd_count - r0);
    else n_pass++;
    n_total++;
    if (m_valid !== 1'b1 || m_data !== w[0])
      $display("FAIL bp_head: valid=%b data=%h required 1/%h", m_valid, m_data, w[0]);
    else n_pass++;
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (m_valid !== 1'b1 || m_data !== w[i])
        $display("FAIL bp_stream[%0d]: valid=%b data=%h required 1/%h", i, m_valid, m_data, w[i]);
      else n_pass++;
      @(negedge clk);
    end
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != 5) $display("FAIL bp_count: ok=%b got %0d required 5", ok, got.size());
    else n_pass++;
  endtask

  task automatic test_alternating;
    logic [7:0] w [20];
    bit ok;
    got.delete();
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w[i] = 8'($urandom);
      push_word(w[i]);
    end
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      m_ready = (c % 2 == 0);
      @(negedge clk);
    end
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != 20) $display("FAIL alt_count: ok=%b got %0d required 20", ok, got.size());
    else n_pass++;
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      n_total++;
      if (got[i] !== w[i]) $display("FAIL alt_word[%0d]: got %h required %h", i, got[i], w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_empty_edge;
    int r0, p0;
    got.delete();
    en = 1'b1; m_ready = 1'b1;
    r0 = rd_count; p0 = pop_count;
    @(negedge clk);
    push_word(8'h5A);
    repeat (6) @(negedge clk);
    #1;
    n_total++;
    if (rd_count - r0 != 1 || pop_count - p0 != 1)
      $display("FAIL edge_pulses: reads=%0d pops=%0d required 1/1", rd_count - r0, pop_count - p0);
    else n_pass++;
    n_total++;
    if (got.size() != 1 || got[0] !== 8'h5A || m_valid !== 1'b0)
      $display("FAIL edge_word: count=%0d valid=%b required one 5A then idle", got.size(), m_valid);
    else n_pass++;
  endtask

  task automatic test_flush;
    bit ok;
    got.delete();
    en = 1'b0; m_ready = 1'b0;
    for (int i = 6; i < 10; i++) push_word(8'(i));
    @(negedge clk);
    en = 1'b1;
    #1;
    n_total++;
    if (r_en !== 1'b1) $display("FAIL flush_rd6: r_en=%b required 1", r_en);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (r_en !== 1'b1) $display("FAIL flush_rd7: r_en=%b required 1", r_en);
    else n_pass++;
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_total++;
    if (r_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'd6)
      $display("FAIL flush_cycle: r_en=%b valid=%b data=%h required 0/1/06", r_en, m_valid, m_data);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_total++;
    if (m_valid !== 1'b0) $display("FAIL flush_valid: valid=%b required 0", m_valid);
    else n_pass++;
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
    n_total++;
    if (word_count !== 16'd0) $display("FAIL flush_wc: got %0d required 0", word_count);
    else n_pass++;
`endif
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != 2 || got[0] !== 8'd8 || got[1] !== 8'd9)
      $display("FAIL flush_after: ok=%b count=%0d required words 08,09", ok, got.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] w [3];
    bit ok;
    got.delete();
    en = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      push_word(w[i]);
    end
    @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_total++;
    if (m_valid !== 1'b1 || m_data !== w[0] || r_en !== 1'b0)
      $display("FAIL rmid_full: valid=%b data=%h r_en=%b required 1/%h/0", m_valid, m_data, r_en, w[0]);
    else n_pass++;
    #1 rrst_n = 1'b0;
    #1;
    n_total++;
    if (m_valid !== 1'b0 || r_en !== 1'b0 || m_data !== 8'h00)
      $display("FAIL rmid_reset: valid=%b r_en=%b data=%h required 0/0/00", m_valid, r_en, m_data);
    else n_pass++;
`ifdef FIFO_RD_DRAIN_WORD_COUNT_EN
    n_total++;
    if (word_count !== 16'd0) $display("FAIL rmid_wc: got %0d required 0", word_count);
    else n_pass++;
`endif
    @(negedge clk);
    rrst_n = 1'b1;
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != 1 || got[0] !== w[2])
      $display("FAIL rmid_after: ok=%b count=%0d required one word %h", ok, got.size(), w[2]);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] exp_q [$];
    logic [7:0] v;
    bit ok;
    got.delete();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      en      = ($urandom_range(0, 3) != 0);
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        v = 8'($urandom);
        push_word(v);
        exp_q.push_back(v);
      end
    end
    wait_idle(ok);
    n_total++;
    if (!ok || got.size() != exp_q.size())
      $display("FAIL rand_count: ok=%b got %0d required %0d", ok, got.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_total++;
      if (got[i] !== exp_q[i]) $display("FAIL rand_word[%0d]: got %h required %h", i, got[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_alternating();
    test_empty_edge();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
